// File: rtl/blk_xfer_seq_pkg.sv
// Shared definitions for the block-transfer (LDM/STM) sequencer.
//   state_t      : sequencer states, also exported on the debug state port
//   PC_REG       : register number of the program counter (r15)
//   popcount16() : number of registers named in a 16-bit register list
//   times4()     : byte span of n word transfers, widened to 32 bits
package blk_xfer_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    XFER  = 2'd1,
    WBACK = 2'd2,
    FIN   = 2'd3
  } state_t;

  localparam logic [3:0] PC_REG = 4'd15;

  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] cnt;
    cnt = '0;
    for (int i = 0; i < 16; i++) begin
      cnt = cnt + {4'd0, v[i]};
    end
    return cnt;
  endfunction

  function automatic logic [31:0] times4(input logic [4:0] n);
    return {25'd0, n, 2'b00};
  endfunction

endpackage

// File: rtl/blk_xfer_seq_if.sv
// Bus bundle between the pipeline (master) and the block-transfer sequencer
// (slave).
//   request : start, is_load, reglist, rn, base, up, pre, wback
//   regfile : ra / rd read port, we / wa / wd write port (r0-r14)
//   pc      : pc_we / pc_wd load path for r15
//   memory  : mem_addr, mem_we, mem_wdata, mem_rdata
//   status  : busy (pipeline stall), done (one-cycle completion pulse)
//   debug   : state (current sequencer state)
// Handshake: start is a one-cycle request that is only sampled while
// busy=0; a request seen while busy=1 is dropped, never queued. done pulses
// for exactly one cycle and busy falls on the following cycle.
interface blk_xfer_seq_if;
  import blk_xfer_seq_pkg::*;

  logic        start;
  logic        is_load;
  logic [15:0] reglist;
  logic [3:0]  rn;
  logic [31:0] base;
  logic        up;
  logic        pre;
  logic        wback;

  logic [3:0]  ra;
  logic [31:0] rd;
  logic        we;
  logic [3:0]  wa;
  logic [31:0] wd;

  logic        pc_we;
  logic [31:0] pc_wd;

  logic [31:0] mem_addr;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic        busy;
  logic        done;
  state_t      state;

  modport slave (
    input  start, is_load, reglist, rn, base, up, pre, wback, rd, mem_rdata,
    output ra, we, wa, wd, pc_we, pc_wd, mem_addr, mem_we, mem_wdata,
    output busy, done, state
  );

  modport master (
    output start, is_load, reglist, rn, base, up, pre, wback, rd, mem_rdata,
    input  ra, we, wa, wd, pc_we, pc_wd, mem_addr, mem_we, mem_wdata,
    input  busy, done, state
  );

endinterface

// File: rtl/blk_xfer_seq_prio_enc16.sv
// 16-bit lowest-set-bit priority encoder.
//   vec : input bit vector
//   idx : index of the lowest set bit (0 when vec is all zero)
//   vld : 1 when any bit of vec is set
module prio_enc16 (
  input  logic [15:0] vec,
  output logic [3:0]  idx,
  output logic        vld
);

  // Scan from the top down so the last hit, i.e. the lowest bit, wins.
  always_comb begin
    idx = '0;
    vld = |vec;
    for (int i = 15; i >= 0; i--) begin
      if (vec[i]) idx = i[3:0];
    end
  end

endmodule

// File: rtl/blk_xfer_seq.sv
// Block-transfer sequencer for LDM/STM.
//   clk   : system clock, all state on rising edge
//   reset : asynchronous, active-high, clears all state
//   bus   : blk_xfer_seq_if.slave (request, regfile, pc, memory, status,
//           debug state)
// One register is transferred per XFER cycle, lowest-numbered first, at
// ascending word addresses. An optional base writeback follows, then a
// one-cycle FIN that pulses done. Every output is a decode of registered
// state (rd / mem_rdata are only passed through as data), so values are
// stable for the whole cycle.
module blk_xfer_seq
  import blk_xfer_seq_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  blk_xfer_seq_if.slave   bus
);

  state_t      state_q, state_d;
  logic [15:0] mask_q;
  logic [3:0]  rn_q;
  logic        load_q;
  logic        wb_take_q;
  logic [4:0]  cnt_q;
  logic [31:0] addr_q;
  logic [31:0] final_q;

  logic [3:0]  cur_reg;
  logic        cur_vld;

  logic [4:0]  n_in;
  logic [31:0] span_in;
  logic [31:0] start_addr;
  logic [31:0] final_base;
  logic        wb_take_in;
  logic        accept;

  prio_enc16 u_prio (
    .vec (mask_q),
    .idx (cur_reg),
    .vld (cur_vld)
  );

  // Request decode, only meaningful on the accepting edge.
  always_comb begin
    n_in    = popcount16(bus.reglist);
    span_in = times4(n_in);
    unique case ({bus.up, bus.pre})
      2'b10:   start_addr = bus.base;
      2'b11:   start_addr = bus.base + 32'd4;
      2'b00:   start_addr = bus.base - span_in + 32'd4;
      default: start_addr = bus.base - span_in;
    endcase
    final_base = bus.up ? (bus.base + span_in) : (bus.base - span_in);
    // Writeback is dropped when a load overwrites the base register itself,
    // and never targets the PC.
    wb_take_in = bus.wback && (bus.rn != PC_REG) &&
                 !(bus.is_load && bus.reglist[bus.rn]);
  end

  assign accept = (state_q == IDLE) && bus.start;

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (bus.start) state_d = (n_in == 5'd0) ? FIN : XFER;
      XFER:  if (cnt_q <= 5'd1) state_d = wb_take_q ? WBACK : FIN;
      WBACK: state_d = FIN;
      FIN:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mask_q    <= '0;
      rn_q      <= '0;
      load_q    <= 1'b0;
      wb_take_q <= 1'b0;
      cnt_q     <= '0;
      addr_q    <= '0;
      final_q   <= '0;
    end else if (accept) begin
      mask_q    <= bus.reglist;
      rn_q      <= bus.rn;
      load_q    <= bus.is_load;
      wb_take_q <= wb_take_in;
      cnt_q     <= n_in;
      addr_q    <= start_addr;
      final_q   <= final_base;
    end else if (state_q == XFER) begin
      mask_q <= mask_q & ~(16'd1 << cur_reg);
      cnt_q  <= cnt_q - 5'd1;
      addr_q <= addr_q + 32'd4;
    end
  end

  // Output decode; everything defaults to zero outside its active cycle.
  logic [3:0]  ra_c, wa_c;
  logic [31:0] wd_c, pc_wd_c, mem_addr_c, mem_wdata_c;
  logic        we_c, pc_we_c, mem_we_c;

  always_comb begin
    ra_c        = '0;
    we_c        = 1'b0;
    wa_c        = '0;
    wd_c        = '0;
    pc_we_c     = 1'b0;
    pc_wd_c     = '0;
    mem_addr_c  = '0;
    mem_we_c    = 1'b0;
    mem_wdata_c = '0;
    if (state_q == XFER && cur_vld) begin
      mem_addr_c = addr_q;
      if (!load_q) begin
        ra_c        = cur_reg;
        mem_we_c    = 1'b1;
        mem_wdata_c = bus.rd;
      end else if (cur_reg == PC_REG) begin
        pc_we_c = 1'b1;
        pc_wd_c = bus.mem_rdata;
      end else begin
        we_c = 1'b1;
        wa_c = cur_reg;
        wd_c = bus.mem_rdata;
      end
    end else if (state_q == WBACK) begin
      we_c = 1'b1;
      wa_c = rn_q;
      wd_c = final_q;
    end
  end

  assign bus.ra        = ra_c;
  assign bus.we        = we_c;
  assign bus.wa        = wa_c;
  assign bus.wd        = wd_c;
  assign bus.pc_we     = pc_we_c;
  assign bus.pc_wd     = pc_wd_c;
  assign bus.mem_addr  = mem_addr_c;
  assign bus.mem_we    = mem_we_c;
  assign bus.mem_wdata = mem_wdata_c;
  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = (state_q == FIN);
  assign bus.state     = state_q;

endmodule

// File: tb/tb_blk_xfer_seq.sv
// Testbench for blk_xfer_seq: per-cycle vector table (inputs driven and
// outputs expected within one clock cycle) plus hand-written reset
// sequences. Regfile read data is modelled as 0xA0000000|ra, memory read
// data as 0xD0000000^mem_addr.
module tb_blk_xfer_seq;
  import blk_xfer_seq_pkg::*;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  blk_xfer_seq_if bus ();

  blk_xfer_seq dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  assign bus.rd        = 32'hA000_0000 | {28'd0, bus.ra};
  assign bus.mem_rdata = 32'hD000_0000 ^ bus.mem_addr;

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        start;
    logic        is_load;
    logic [15:0] reglist;
    logic [3:0]  rn;
    logic [31:0] base;
    logic        up;
    logic        pre;
    logic        wback;
    logic        we;
    logic [3:0]  wa;
    logic [31:0] wd;
    logic        pc_we;
    logic [31:0] pc_wd;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  ra;
    logic        busy;
    logic        done;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Start request; the sequencer is expected to be idle in that cycle.
  task automatic push_start(input logic ld, input logic [15:0] rl, input logic [3:0] rn,
                            input logic [31:0] base, input logic up, input logic pre,
                            input logic wb);
    vec_t v;
    v = '{start: 1'b1, is_load: ld, reglist: rl, rn: rn, base: base, up: up, pre: pre,
          wback: wb, we: 1'b0, wa: '0, wd: '0, pc_we: 1'b0, pc_wd: '0, mem_we: 1'b0,
          mem_addr: '0, mem_wdata: '0, ra: '0, busy: 1'b0, done: 1'b0};
    vecs.push_back(v);
  endtask

  // Expected-output cycle. With st=1 a conflicting request is driven, which
  // must be ignored because the sequencer is busy.
  task automatic push_x(input logic st, input logic we, input logic [3:0] wa,
                        input logic [31:0] wd, input logic pc_we, input logic [31:0] pc_wd,
                        input logic mem_we, input logic [31:0] mem_addr,
                        input logic [31:0] mem_wdata, input logic [3:0] ra,
                        input logic busy, input logic done);
    vec_t v;
    v = '{start: st, is_load: st, reglist: st ? 16'hFFFF : 16'h0, rn: 4'd0,
          base: 32'h5555_0000, up: 1'b1, pre: 1'b0, wback: st, we: we, wa: wa, wd: wd,
          pc_we: pc_we, pc_wd: pc_wd, mem_we: mem_we, mem_addr: mem_addr,
          mem_wdata: mem_wdata, ra: ra, busy: busy, done: done};
    vecs.push_back(v);
  endtask

  task automatic push_fin();
    push_x(1'b0, 1'b0, 4'd0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 4'd0, 1'b1, 1'b1);
  endtask

  task automatic chk_outputs(input string tag, input vec_t v);
    chk({tag, " we"},        32'(bus.we),        32'(v.we));
    chk({tag, " wa"},        32'(bus.wa),        32'(v.wa));
    chk({tag, " wd"},        bus.wd,             v.wd);
    chk({tag, " pc_we"},     32'(bus.pc_we),     32'(v.pc_we));
    chk({tag, " pc_wd"},     bus.pc_wd,          v.pc_wd);
    chk({tag, " mem_we"},    32'(bus.mem_we),    32'(v.mem_we));
    chk({tag, " mem_addr"},  bus.mem_addr,       v.mem_addr);
    chk({tag, " mem_wdata"}, bus.mem_wdata,      v.mem_wdata);
    chk({tag, " ra"},        32'(bus.ra),        32'(v.ra));
    chk({tag, " busy"},      32'(bus.busy),      32'(v.busy));
    chk({tag, " done"},      32'(bus.done),      32'(v.done));
  endtask

  task automatic drive_start(input logic st, input logic ld, input logic [15:0] rl,
                             input logic [3:0] rn, input logic [31:0] base,
                             input logic up, input logic pre, input logic wb);
    bus.start   = st;
    bus.is_load = ld;
    bus.reglist = rl;
    bus.rn      = rn;
    bus.base    = base;
    bus.up      = up;
    bus.pre     = pre;
    bus.wback   = wb;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset    = 1'b1;
    drive_start(1'b0, 1'b0, 16'h0, 4'd0, 32'h0, 1'b0, 1'b0, 1'b0);

    // STM r1-r3, IA, writeback r13 = 0x10C, done in cycle 5
    push_start(1'b0, 16'h000E, 4'd13, 32'h100, 1'b1, 1'b0, 1'b1);
    push_x(0, 0, 4'd0, 32'h0, 0, 32'h0, 1, 32'h100, 32'hA000_0001, 4'd1, 1, 0);
    push_x(0, 0, 4'd0, 32'h0, 0, 32'h0, 1, 32'h104, 32'hA000_0002, 4'd2, 1, 0);
    push_x(0, 0, 4'd0, 32'h0, 0, 32'h0, 1, 32'h108, 32'hA000_0003, 4'd3, 1, 0);
    push_x(0, 1, 4'd13, 32'h10C, 0, 32'h0, 0, 32'h0, 32'h0, 4'd0, 1, 0);
    push_fin();
    // LDM r0,r1,pc, IB from 0x200
    push_start(1'b1, 16'h8003, 4'd0, 32'h200, 1'b1, 1'b1, 1'b0);
    push_x(0, 1, 4'd0, 32'hD000_0204, 0, 32'h0, 0, 32'h204, 32'h0, 4'd0, 1, 0);
    push_x(0, 1, 4'd1, 32'hD000_0208, 0, 32'h0, 0, 32'h208, 32'h0, 4'd0, 1, 0);
    push_x(0, 0, 4'd0, 32'h0, 1, 32'hD000_020C, 0, 32'h20C, 32'h0, 4'd0, 1, 0);
    push_fin();
    // LDM r4,r5, DB from 0x40, rn=4 in list -> no writeback
    push_start(1'b1, 16'h0030, 4'd4, 32'h40, 1'b0, 1'b1, 1'b1);
    push_x(0, 1, 4'd4, 32'hD000_0038, 0, 32'h0, 0, 32'h38, 32'h0, 4'd0, 1, 0);
    push_x(0, 1, 4'd5, 32'hD000_003C, 0, 32'h0, 0, 32'h3C, 32'h0, 4'd0, 1, 0);
    push_fin();
    // Empty list: straight to FIN, no writeback despite wback=1
    push_start(1'b0, 16'h0000, 4'd2, 32'h500, 1'b1, 1'b0, 1'b1);
    push_fin();
    // STM r0,r1, DA from 0x80, writeback r3 = 0x78
    push_start(1'b0, 16'h0003, 4'd3, 32'h80, 1'b0, 1'b0, 1'b1);
    push_x(0, 0, 4'd0, 32'h0, 0, 32'h0, 1, 32'h7C, 32'hA000_0000, 4'd0, 1, 0);
    push_x(0, 0, 4'd0, 32'h0, 0, 32'h0, 1, 32'h80, 32'hA000_0001, 4'd1, 1, 0);
    push_x(0, 1, 4'd3, 32'h78, 0, 32'h0, 0, 32'h0, 32'h0, 4'd0, 1, 0);
    push_fin();
    // STM r1,r2, DA from 0x1000 with rn=15: writeback suppressed
    push_start(1'b0, 16'h0006, 4'd15, 32'h1000, 1'b0, 1'b0, 1'b1);
    push_x(0, 0, 4'd0, 32'h0, 0, 32'h0, 1, 32'hFFC, 32'hA000_0001, 4'd1, 1, 0);
    push_x(0, 0, 4'd0, 32'h0, 0, 32'h0, 1, 32'h1000, 32'hA000_0002, 4'd2, 1, 0);
    push_fin();
    // STM r0,r7, IA from 0xFFFFFFFC wraps; start re-asserted while busy
    push_start(1'b0, 16'h0081, 4'd2, 32'hFFFF_FFFC, 1'b1, 1'b0, 1'b0);
    push_x(1, 0, 4'd0, 32'h0, 0, 32'h0, 1, 32'hFFFF_FFFC, 32'hA000_0000, 4'd0, 1, 0);
    push_x(1, 0, 4'd0, 32'h0, 0, 32'h0, 1, 32'h0000_0000, 32'hA000_0007, 4'd7, 1, 0);
    push_x(1, 0, 4'd0, 32'h0, 0, 32'h0, 0, 32'h0, 32'h0, 4'd0, 1, 1);
    push_x(0, 0, 4'd0, 32'h0, 0, 32'h0, 0, 32'h0, 32'h0, 4'd0, 0, 0);

    // Reset state
    #2;
    chk("rst busy", 32'(bus.busy), 32'd0);
    chk("rst done", 32'(bus.done), 32'd0);
    chk("rst state", 32'(bus.state), 32'(IDLE));
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rel we", 32'(bus.we), 32'd0);
    chk("rel mem_we", 32'(bus.mem_we), 32'd0);

    // Table
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive_start(vecs[i].start, vecs[i].is_load, vecs[i].reglist, vecs[i].rn,
                  vecs[i].base, vecs[i].up, vecs[i].pre, vecs[i].wback);
      #1;
      chk_outputs($sformatf("v%0d", i), vecs[i]);
    end

    // Reset in the 2nd XFER cycle of a 4-register STM
    @(negedge clk);
    drive_start(1'b1, 1'b0, 16'h000F, 4'd0, 32'h300, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    drive_start(1'b0, 1'b0, 16'h0, 4'd0, 32'h0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("mid x1 mem_addr", bus.mem_addr, 32'h300);
    @(posedge clk);
    #2;
    chk("mid x2 mem_we", 32'(bus.mem_we), 32'd1);
    chk("mid x2 mem_addr", bus.mem_addr, 32'h304);
    reset = 1'b1;
    #1;
    chk("mid rst mem_we", 32'(bus.mem_we), 32'd0);
    chk("mid rst mem_addr", bus.mem_addr, 32'h0);
    chk("mid rst busy", 32'(bus.busy), 32'd0);
    chk("mid rst state", 32'(bus.state), 32'(IDLE));
    @(negedge clk);
    reset = 1'b0;
    drive_start(1'b1, 1'b1, 16'h0001, 4'd0, 32'h10, 1'b1, 1'b0, 1'b0);
    #1;
    chk("post rel we", 32'(bus.we), 32'd0);
    chk("post rel mem_we", 32'(bus.mem_we), 32'd0);
    chk("post rel pc_we", 32'(bus.pc_we), 32'd0);
    @(negedge clk);
    drive_start(1'b0, 1'b0, 16'h0, 4'd0, 32'h0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("post ld we", 32'(bus.we), 32'd1);
    chk("post ld wa", 32'(bus.wa), 32'd0);
    chk("post ld wd", bus.wd, 32'hD000_0010);
    chk("post ld mem_addr", bus.mem_addr, 32'h10);
    @(negedge clk);
    #1;
    chk("post ld done", 32'(bus.done), 32'd1);
    @(negedge clk);
    #1;
    chk("post ld idle", 32'(bus.busy), 32'd0);

    // Reset during WBACK (STM r1, writeback r2)
    drive_start(1'b1, 1'b0, 16'h0002, 4'd2, 32'h20, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    drive_start(1'b0, 1'b0, 16'h0, 4'd0, 32'h0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    chk("wb we", 32'(bus.we), 32'd1);
    chk("wb wd", bus.wd, 32'h24);
    reset = 1'b1;
    #1;
    chk("wb rst we", 32'(bus.we), 32'd0);
    chk("wb rst wd", bus.wd, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("wb rel busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    #1;
    chk("wb idle stays", 32'(bus.busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/blk_xfer_seq.md
BLK_XFER_SEQ -- requirements
Module: blk_xfer_seq

Interface
REQ-001 SHALL have ports: clk  in  1  system clock, all state on rising edge.
REQ-002 SHALL have ports: reset  in  1  asynchronous, active-high; clears all state.
REQ-003 SHALL have ports: start  in  1  one-cycle request, sampled only in IDLE; is_load  in  1  1=LDM, 0=STM; reglist  in  16  register list; rn  in  4  base register number; base  in  32  base value; up  in  1  U bit; pre  in  1  P bit; wback  in  1  W bit.
REQ-004 SHALL have ports: ra  out  4  regfile read address; rd  in  32  regfile read data (combinational).
REQ-005 SHALL have ports: we  out  1; wa  out  4; wd  out  32  regfile write port for r0-r14.
REQ-006 SHALL have ports: pc_we  out  1; pc_wd  out  32  r15 load path.
REQ-007 SHALL have ports: mem_addr  out  32; mem_we  out  1; mem_wdata  out  32; mem_rdata  in  32  (combinational read).
REQ-008 SHALL have ports: busy  out  1  (state != IDLE, used as pipeline stall); done  out  1  one-cycle completion pulse.

Function
REQ-009 SHALL implement states IDLE, XFER, WBACK, FIN; IDLE->XFER on start with n>0, IDLE->FIN on start with n=0.
REQ-010 SHALL latch reglist as remaining mask, rn, is_load, wback, and n=popcount(reglist) (5 bits) on the accepting edge.
REQ-011 SHALL compute the start address modulo 2^32: up&~pre: base; up&pre: base+4; ~up&~pre: base-4n+4; ~up&pre: base-4n.
REQ-012 SHALL compute the final base as base+4n (up) or base-4n (~up), modulo 2^32.
REQ-013 SHALL, in XFER, perform one transfer per cycle on the lowest set bit of the mask, clear that bit, and add 4 to mem_addr; XFER ends after exactly n cycles.
REQ-014 SHALL, for STM in XFER: ra=current reg, mem_wdata=rd, mem_we=1; we=0.
REQ-015 SHALL, for LDM in XFER with reg<15: we=1, wa=reg, wd=mem_rdata; mem_we=0.
REQ-016 SHALL, for LDM with reg=15: pc_we=1, pc_wd=mem_rdata, we=0.
REQ-017 SHALL enter WBACK after XFER only when wback=1 and not (is_load and rn in reglist); otherwise go to FIN.
REQ-018 SHALL, in WBACK, drive we=1, wa=rn, wd=final base for one cycle; wback with rn=15 SHALL be suppressed (WBACK skipped).
REQ-019 SHALL assert done for exactly one cycle in FIN, then return to IDLE.
REQ-020 SHALL hold we, pc_we and mem_we low in IDLE and FIN; ra, wa, wd, mem_addr, mem_wdata SHALL be 0 when their enables are low.
REQ-021 SHALL drive all outputs as decodes of registered state, stable for the full cycle so the regfile falling-edge write sees settled values.
REQ-022 SHALL ignore start while busy=1.
REQ-023 SHALL, for n=0, perform no transfers and no writeback; busy high one cycle, done pulses that cycle.
REQ-024 SHALL, for STM with rn in reglist, store the original (pre-writeback) value of rn.
REQ-025 Latency: start edge -> done = n + (WBACK taken ? 1 : 0) + 1 cycles.

Reset
REQ-026 SHALL, on reset asserted (any time, including mid-XFER/WBACK), go to IDLE asynchronously with all outputs 0 and mask, counters, and address cleared.
REQ-027 SHALL issue no write enable in the cycle reset is released; start is accepted from the first rising edge after release.

Structure
REQ-028 SHALL place the state enumeration and the constant PC_REG=4'd15 in the shared pipeline package.
REQ-029 SHALL use one sub-module, prio_enc16 (16-bit lowest-set-bit encoder, 4-bit index plus valid output).

Verification
REQ-030 STM, reglist=0x000E, base=0x100, up=1, pre=0, wback=1, rn=13 -> writes to 0x100/0x104/0x108 of r1/r2/r3; WBACK r13=0x10C; done on cycle 5.
REQ-031 LDM, reglist=0x8003, base=0x200, up=1, pre=1 -> r0<-mem[0x204], r1<-mem[0x208], pc_we with mem[0x20C]; we=0 on the r15 cycle.
REQ-032 LDM, up=0, pre=1, reglist=0x0030, base=0x40, wback=1, rn=4 -> addresses 0x38, 0x3C; no WBACK since rn is in the list; r4 holds the loaded value.
REQ-033 reglist=0x0000, start -> busy 1 cycle, done pulse, no we/mem_we/pc_we.
REQ-034 Reset asserted on the 2nd XFER cycle of a 4-register STM -> immediate IDLE, mem_we=0; the next start is accepted normally.
REQ-035 start re-asserted during busy -> ignored; base=0xFFFFFFFC, up=1, pre=0, 2 regs -> addresses 0xFFFFFFFC, 0x00000000.
